btn_debouncer: RTL

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

---
 rtl/btn_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_debouncer.sv | 117 +++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Holds the FSM state encoding, the 100 MHz default limits and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_CHK,
    S_HELD,
    S_RELEASE_CHK
  } btn_state_e;

  localparam int DEFAULT_DEBOUNCE_LIMIT = 1_000_000;
  localparam int DEFAULT_LONG_LIMIT     = 100_000_000;

  // A limit of 1 still needs one bit to hold the value 0.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0 on the asynchronous active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/btn_debouncer.sv
// Push-button debouncer: synchronizes the raw level, qualifies press/release
// over DEBOUNCE_LIMIT stable samples and flags a long press after LONG_LIMIT held cycles.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int LONG_LIMIT     = DEFAULT_LONG_LIMIT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse
);

  localparam int DW = cnt_width(DEBOUNCE_LIMIT);
  localparam int LW = cnt_width(LONG_LIMIT);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [LW-1:0] LLAST = LW'(LONG_LIMIT - 1);

  if (DEBOUNCE_LIMIT < 1 || LONG_LIMIT <= DEBOUNCE_LIMIT) begin : g_bad_limits
    $error("btn_debouncer: need DEBOUNCE_LIMIT >= 1 and LONG_LIMIT > DEBOUNCE_LIMIT");
  end

  logic          btn_s;
  btn_state_e    state_q;
  logic [DW-1:0] dcnt_q;
  logic [LW-1:0] lcnt_q;
  logic          fired_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn),
    .o_q     (btn_s)
  );

  // Pulses default low each cycle and are raised only on the qualifying transition,
  // so at most one of them can be high in any cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      dcnt_q    <= '0;
      lcnt_q    <= '0;
      fired_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (btn_s) begin
            state_q <= S_PRESS_CHK;
            dcnt_q  <= '0;
          end
        end
        S_PRESS_CHK: begin
          if (!btn_s) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
          end else if (dcnt_q == DLAST) begin
            state_q <= S_HELD;
            level_q <= 1'b1;
            press_q <= 1'b1;
            lcnt_q  <= '0;
            fired_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        S_HELD: begin
          if (!btn_s) begin
            state_q <= S_RELEASE_CHK;
            dcnt_q  <= '0;
          end else if (lcnt_q == LLAST) begin
            // Saturated: fire once, then sit here until release.
            if (!fired_q) begin
              long_q  <= 1'b1;
              fired_q <= 1'b1;
            end
          end else begin
            lcnt_q <= lcnt_q + LW'(1);
          end
        end
        S_RELEASE_CHK: begin
          if (btn_s) begin
            state_q <= S_HELD;
          end else if (dcnt_q == DLAST) begin
            state_q   <= S_IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            lcnt_q    <= '0;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_btn_level     = level_q;
  assign o_press_pulse   = press_q;
  assign o_release_pulse = release_q;
  assign o_long_pulse    = long_q;

endmodule
